// File: rtl/axi_mst_wr_burst.sv
// AXI4 write-burst master: streams words from an AXI-Stream FIFO into fixed-length
// INCR bursts at consecutive aligned addresses, with bounded outstanding bursts.
module axi_mst_wr_burst #(
  parameter int ID_WIDTH        = 1,
  parameter int DATA_WIDTH      = 64,
  parameter int BURST_LEN       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIFO_DEPTH      = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    START_REG,
  input  logic                    trigger,
  input  logic [31:0]             ADDR_REG,
  input  logic [31:0]             NBURST_REG,
  output logic                    STATUS_BUSY,
  output logic                    STATUS_DONE,
  output logic [15:0]             ERR_CNT,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [31:0]             m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awregion,
  output logic [3:0]              m_axi_awqos,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam int BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
  localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int IDX_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] ADDR_MASK = 32'(BURST_BYTES - 1);

  if (BURST_BYTES > 4096) begin : g_bad_burst_bytes
    $error("axi_mst_wr_burst: BURST_LEN*DATA_WIDTH/8 exceeds 4096 bytes");
  end
  if (FIFO_DEPTH < BURST_LEN) begin : g_bad_fifo_depth
    $error("axi_mst_wr_burst: FIFO_DEPTH must be at least BURST_LEN");
  end

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_LOAD, S_RUN, S_FINISH, S_END} state_t;

  state_t state, state_nxt;

  logic start_p0, start_p1, trig_p0, trig_p1;
  logic [31:0] nburst, addr, aw_cnt, w_cnt, b_cnt;
  logic [BEAT_W-1:0] beat;
  logic [15:0] err_cnt;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [CNT_W-1:0] fifo_cnt;
  logic fifo_full, fifo_empty, push, pop;
  logic aw_hs, w_hs, b_hs, run;

  logic unused_ok;
  assign unused_ok = ^{s_axis_tstrb, s_axis_tlast, m_axi_bid};

  // Stage p0/p1: level synchronisers for the asynchronous control levels
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_p0 <= 1'b0;
      start_p1 <= 1'b0;
      trig_p0  <= 1'b0;
      trig_p1  <= 1'b0;
    end else begin
      start_p0 <= START_REG;
      start_p1 <= start_p0;
      trig_p0  <= trigger;
      trig_p1  <= trig_p0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start_p1) state_nxt = S_ARMED;
      S_ARMED:  if (trig_p1) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = (NBURST_REG == 32'd0) ? S_FINISH : S_RUN;
      S_RUN:    if (b_cnt == nburst) state_nxt = S_FINISH;
      S_FINISH: if (!trig_p1) state_nxt = S_END;
      S_END:    if (!start_p1) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign run         = (state == S_RUN);
  assign STATUS_BUSY = (state == S_LOAD) || run;
  assign STATUS_DONE = (state == S_FINISH) || (state == S_END);
  assign ERR_CNT     = err_cnt;

  // Valids depend only on counters, so awvalid cannot drop before its handshake
  assign m_axi_awvalid = run && (aw_cnt < nburst) &&
                         ((aw_cnt - b_cnt) < 32'(MAX_OUTSTANDING));
  assign m_axi_wvalid  = run && !fifo_empty && (w_cnt < aw_cnt);
  assign m_axi_bready  = run;

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;
  assign b_hs  = m_axi_bvalid && m_axi_bready;

  assign m_axi_awid     = '0;
  assign m_axi_awaddr   = addr;
  assign m_axi_awlen    = 8'(BURST_LEN - 1);
  assign m_axi_awsize   = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_awburst  = 2'b01;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = 4'b0000;
  assign m_axi_awprot   = 3'b010;
  assign m_axi_awregion = 4'b0000;
  assign m_axi_awqos    = 4'b0000;
  assign m_axi_wdata    = mem[rd_idx];
  assign m_axi_wstrb    = '1;
  assign m_axi_wlast    = (beat == BEAT_W'(BURST_LEN - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nburst  <= '0;
      aw_cnt  <= '0;
      w_cnt   <= '0;
      b_cnt   <= '0;
      beat    <= '0;
      err_cnt <= '0;
    end else if (state == S_LOAD) begin
      nburst  <= NBURST_REG;
      aw_cnt  <= '0;
      w_cnt   <= '0;
      b_cnt   <= '0;
      beat    <= '0;
      err_cnt <= '0;
    end else begin
      if (aw_hs) aw_cnt <= aw_cnt + 32'd1;
      if (b_hs)  b_cnt  <= b_cnt + 32'd1;
      if (w_hs) begin
        if (m_axi_wlast) begin
          beat  <= '0;
          w_cnt <= w_cnt + 32'd1;
        end else begin
          beat <= beat + 1'b1;
        end
      end
      if (b_hs && (m_axi_bresp != 2'b00) && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
    end
  end

  // Burst-aligned base keeps every burst inside one 4 KB page; wraps modulo 2^32
  always_ff @(posedge clk) begin
    if (state == S_LOAD) addr <= ADDR_REG & ~ADDR_MASK;
    else if (aw_hs)      addr <= addr + 32'(BURST_BYTES);
  end

  assign fifo_full     = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty    = (fifo_cnt == '0);
  assign s_axis_tready = !fifo_full;
  assign push          = s_axis_tvalid && !fifo_full;
  assign pop           = w_hs;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_idx <= (wr_idx == IDX_W'(FIFO_DEPTH - 1)) ? '0 : wr_idx + 1'b1;
      if (pop)  rd_idx <= (rd_idx == IDX_W'(FIFO_DEPTH - 1)) ? '0 : rd_idx + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= s_axis_tdata;
  end

endmodule

// File: tb/tb_axi_mst_wr_burst.sv
// Scoreboard bench for axi_mst_wr_burst: stimulus pushes expected AW addresses and
// W beats into queues; a negedge monitor pops and compares on every handshake.
module tb_axi_mst_wr_burst;

  localparam int DW = 64;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic START_REG = 1'b0, trigger = 1'b0;
  logic [31:0] ADDR_REG = '0, NBURST_REG = '0;
  logic STATUS_BUSY, STATUS_DONE;
  logic [15:0] ERR_CNT;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [DW/8-1:0] s_axis_tstrb = '1;
  logic s_axis_tlast = 1'b0, s_axis_tvalid = 1'b0, s_axis_tready;
  logic [0:0] m_axi_awid, m_axi_bid = '0;
  logic [31:0] m_axi_awaddr;
  logic [7:0] m_axi_awlen;
  logic [2:0] m_axi_awsize, m_axi_awprot;
  logic [1:0] m_axi_awburst, m_axi_bresp = 2'b00;
  logic m_axi_awvalid, m_axi_awready = 1'b1, m_axi_awlock;
  logic [3:0] m_axi_awcache, m_axi_awregion, m_axi_awqos;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic m_axi_wlast, m_axi_wvalid, m_axi_wready = 1'b1;
  logic m_axi_bvalid = 1'b0, m_axi_bready;

  axi_mst_wr_burst #(.ID_WIDTH(1), .DATA_WIDTH(DW), .BURST_LEN(16),
                     .MAX_OUTSTANDING(4), .FIFO_DEPTH(64)) dut (
    .clk(clk), .rstn(rstn), .START_REG(START_REG), .trigger(trigger),
    .ADDR_REG(ADDR_REG), .NBURST_REG(NBURST_REG), .STATUS_BUSY(STATUS_BUSY),
    .STATUS_DONE(STATUS_DONE), .ERR_CNT(ERR_CNT),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot), .m_axi_awregion(m_axi_awregion), .m_axi_awqos(m_axi_awqos),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [DW-1:0] feed_q[$];
  logic [DW:0]   exp_w[$];
  logic [31:0]   exp_aw[$];
  int aw_hs = 0, w_hs = 0, t_hs = 0, b_idx = 0, b_pend = 0;
  int b_allow = 1 << 30, b_base = 0, wcnt_run = 0;
  logic [31:0] err_mask = '0;
  logic [15:0] tag = 16'h0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_words(input int n);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = {tag, 16'h0, 32'(wcnt_run)};
      feed_q.push_back(d);
      exp_w.push_back({(wcnt_run % 16) == 15, d});
      wcnt_run++;
    end
  endtask

  task automatic push_aw(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) exp_aw.push_back((a & ~32'h7F) + 32'(i * 128));
  endtask

  task automatic start_run(input logic [31:0] a, input logic [31:0] n);
    ADDR_REG   = a;
    NBURST_REG = n;
    b_base     = b_idx;
    START_REG  = 1'b1;
    tick(4);
    trigger = 1'b1;
  endtask

  task automatic wait_done(input string nm, input int lim);
    int c = 0;
    while (!STATUS_DONE && c < lim) begin
      tick(1);
      c++;
    end
    chk(nm, STATUS_DONE, 1);
  endtask

  task automatic end_run(input string nm);
    trigger = 1'b0;
    tick(4);
    START_REG = 1'b0;
    tick(4);
    chk(nm, {STATUS_BUSY, STATUS_DONE}, 2'b00);
  endtask

  // Stream source and B-channel slave, both updated just after the active edge
  initial forever begin
    @(posedge clk);
    #1;
    s_axis_tvalid = (feed_q.size() > 0);
    s_axis_tdata  = (feed_q.size() > 0) ? feed_q[0] : '0;
    m_axi_bvalid  = rstn && (b_pend > 0) && (b_idx < b_allow);
    m_axi_bresp   = err_mask[(b_idx - b_base) & 31] ? 2'b10 : 2'b00;
  end

  // Monitor: handshakes seen here complete at the next rising edge
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      exp_aw.delete();
      exp_w.delete();
      feed_q.delete();
      b_pend = 0;
    end else begin
      if (s_axis_tvalid && s_axis_tready) begin
        void'(feed_q.pop_front());
        t_hs++;
      end
      if (m_axi_awvalid && m_axi_awready) begin
        aw_hs++;
        if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
        else chk("awaddr", m_axi_awaddr, exp_aw.pop_front());
        chk("aw_ctl", {m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst},
            {1'b0, 8'd15, 3'd3, 2'b01});
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_hs++;
        if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
        else chk("wbeat", {m_axi_wlast, m_axi_wdata}, exp_w.pop_front());
        if (m_axi_wlast) b_pend++;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_idx++;
        b_pend--;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, w0, t0, c;
    // Reset state
    #3;
    chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b000);
    chk("rst_status", {STATUS_BUSY, STATUS_DONE, ERR_CNT}, 18'h0);
    tick(2);
    rstn = 1'b1;
    tick(2);
    chk("rst_tready", s_axis_tready, 1);
    chk("aw_const", {m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awregion, m_axi_awqos},
        {1'b0, 4'h0, 3'b010, 4'h0, 4'h0});
    chk("wstrb", m_axi_wstrb, 8'hFF);

    // Three bursts, unaligned base, slave always ready
    tag = 16'h0034; wcnt_run = 0; w0 = w_hs;
    push_aw(32'h1000_0010, 3);
    push_words(48);
    start_run(32'h1000_0010, 3);
    tick(4);
    chk("busy_run", STATUS_BUSY, 1);
    wait_done("done_3b", 500);
    chk("beats_3b", w_hs - w0, 48);
    chk("q_3b", {exp_w.size() == 0, exp_aw.size() == 0}, 2'b11);
    end_run("idle_3b");

    // Outstanding limit with B withheld, address wrap at 2^32
    tag = 16'h0035; wcnt_run = 0; a0 = aw_hs;
    b_allow = b_idx;
    push_aw(32'hFFFF_FF00, 6);
    push_words(96);
    start_run(32'hFFFF_FF00, 6);
    tick(150);
    chk("aw_out_4", aw_hs - a0, 4);
    b_allow = b_idx + 1;
    tick(30);
    chk("aw_out_5", aw_hs - a0, 5);
    b_allow = b_idx + 1;
    tick(30);
    chk("aw_out_6", aw_hs - a0, 6);
    b_allow = 1 << 30;
    wait_done("done_6b", 800);
    end_run("idle_6b");

    // FIFO fill with no W drain, then in-order drain
    tag = 16'h0036; wcnt_run = 0; t0 = t_hs;
    m_axi_wready = 1'b0;
    push_words(70);
    tick(100);
    chk("fifo_fill", t_hs - t0, 64);
    chk("tready_full", s_axis_tready, 0);
    a0 = aw_hs; w0 = w_hs;
    push_aw(32'h3000_007F, 5);
    start_run(32'h3000_007F, 5);
    tick(40);
    chk("tready_hold", s_axis_tready, 0);
    chk("aw_no_w", aw_hs - a0, 4);
    push_words(10);
    m_axi_wready = 1'b1;
    wait_done("done_fill", 800);
    chk("drain_all", {w_hs - w0, exp_w.size(), feed_q.size()}, {32'd80, 32'd0, 32'd0});
    end_run("idle_fill");

    // Error responses on bursts 2 and 5 of 8
    tag = 16'h0037; wcnt_run = 0;
    err_mask = 32'b1_0010;
    push_aw(32'h0000_0000, 8);
    push_words(128);
    start_run(32'h0000_0000, 8);
    wait_done("done_err", 1500);
    chk("err_cnt_2", ERR_CNT, 2);
    end_run("idle_err");
    err_mask = '0;

    // Zero bursts: no AXI traffic, ERR_CNT cleared by LOAD
    a0 = aw_hs; w0 = w_hs;
    start_run(32'h0000_1000, 0);
    c = 0;
    while (!STATUS_DONE && c < 20) begin
      tick(1);
      c++;
    end
    chk("nb0_latency", c <= 6, 1);
    chk("nb0_err_clr", ERR_CNT, 0);
    chk("nb0_no_axi", {aw_hs - a0, w_hs - w0}, 64'h0);
    end_run("idle_nb0");

    // Reset mid-burst at beat 7 of the second burst
    tag = 16'h0039; wcnt_run = 0; w0 = w_hs;
    err_mask = 32'b1;
    push_aw(32'h4000_0000, 3);
    push_words(48);
    start_run(32'h4000_0000, 3);
    c = 0;
    while ((w_hs - w0) < 23 && c < 500) begin
      tick(1);
      c++;
    end
    chk("pre_rst_err", ERR_CNT, 1);
    rstn = 1'b0;
    START_REG = 1'b0;
    trigger = 1'b0;
    #1;
    chk("mid_rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b000);
    chk("mid_rst_status", {STATUS_BUSY, STATUS_DONE, ERR_CNT}, 18'h0);
    err_mask = '0;
    tick(2);
    rstn = 1'b1;
    tick(1);
    chk("post_rst_tready", s_axis_tready, 1);
    a0 = aw_hs; w0 = w_hs;
    tick(20);
    chk("post_rst_quiet", {aw_hs - a0, w_hs - w0}, 64'h0);

    // A fresh run works after the reset
    tag = 16'h003A; wcnt_run = 0;
    push_aw(32'h5000_0040, 1);
    push_words(16);
    start_run(32'h5000_0040, 1);
    wait_done("done_after_rst", 300);
    chk("q_after_rst", {exp_w.size() == 0, exp_aw.size() == 0}, 2'b11);
    end_run("idle_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_mst_wr_burst.md
AXI_MST_WR_BURST -- requirements
Module: axi_mst_wr_burst

Interface
REQ-001 ID_WIDTH, 1, AXI ID width.
REQ-002 DATA_WIDTH, 64, data bus bits; power of two, 32..512.
REQ-003 BURST_LEN, 16, beats per burst; power of two, 1..256.
REQ-004 MAX_OUTSTANDING, 4, bursts accepted on AW but without a B response; 1..8.
REQ-005 FIFO_DEPTH, 64, input FIFO words; power of two, >= BURST_LEN.
REQ-006 Elaboration SHALL fail if BURST_LEN*DATA_WIDTH/8 (BURST_BYTES) > 4096.
REQ-007 clk  in  1  single clock for all logic.
REQ-008 rstn  in  1  asynchronous, active-low reset.
REQ-009 START_REG  in  1  arm level; 2-flop synchronised to clk.
REQ-010 trigger  in  1  run level; 2-flop synchronised to clk.
REQ-011 ADDR_REG  in  32  base byte address; low log2(BURST_BYTES) bits ignored.
REQ-012 NBURST_REG  in  32  number of bursts per run; 0 = none.
REQ-013 STATUS_BUSY / STATUS_DONE / ERR_CNT  out  1/1/16  run active / run complete / non-OKAY response count.
REQ-014 s_axis_tdata/tstrb/tlast/tvalid  in  DATA_WIDTH/DATA_WIDTH/8/1/1; s_axis_tready  out  1.
REQ-015 m_axi_awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_WIDTH/32/8/3/1+1/1; m_axi_awready  in  1.
REQ-016 m_axi_awlock/awcache/awprot/awregion/awqos  out  1/4/3/4/4  constants 0/0000/010/0000/0000.
REQ-017 m_axi_wdata/wstrb/wlast/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1/1; m_axi_wready  in  1.
REQ-018 m_axi_bid/bresp/bvalid  in  ID_WIDTH/2/1; m_axi_bready  out  1.

Function
REQ-019 awid=0, awlen=BURST_LEN-1, awsize=log2(DATA_WIDTH/8), awburst=INCR, wstrb all ones; tstrb, tlast and bid ignored.
REQ-020 FSM states: IDLE->ARMED (START sync=1); ARMED->LOAD (trigger sync=1); LOAD->RUN, or LOAD->FINISH if NBURST=0; RUN->FINISH (b_cnt==nburst); FINISH->END (trigger sync=0); END->IDLE (START sync=0).
REQ-021 LOAD, 1 cycle: latch nburst, addr=ADDR_REG with low log2(BURST_BYTES) bits cleared, clear aw_cnt/w_cnt/b_cnt/beat; ERR_CNT cleared.
REQ-022 awvalid=1 in RUN while aw_cnt<nburst and (aw_cnt-b_cnt)<MAX_OUTSTANDING; awaddr/awvalid held stable until awready.
REQ-023 AW handshake: aw_cnt+1, addr+=BURST_BYTES modulo 2^32; no burst crosses 4 KB.
REQ-024 Outstanding = aw_cnt-b_cnt; AW and B handshakes in the same cycle leave it unchanged.
REQ-025 Input FIFO, first-word-fall-through: write on tvalid&tready; tready=~full; read on wvalid&wready; wdata=FIFO head.
REQ-026 wvalid = RUN & FIFO not empty & w_cnt<aw_cnt: data SHALL NOT lead its address.
REQ-027 beat counts 0..BURST_LEN-1 on W handshakes; wlast=(beat==BURST_LEN-1); on the last-beat handshake, beat=0 and w_cnt+1.
REQ-028 bready=1 in RUN; B handshake: b_cnt+1; bresp!=00 increments ERR_CNT, saturating at 0xFFFF.
REQ-029 STATUS_BUSY=1 in LOAD and RUN; STATUS_DONE=1 in FINISH and END.
REQ-030 FIFO contents are not flushed between runs.
REQ-031 FIFO full with tvalid=1: tready=0, no word lost or duplicated.

Reset
REQ-032 rstn=0 asynchronously: FSM=IDLE, counters 0, FIFO empty; awvalid/wvalid/bready/BUSY/DONE=0; ERR_CNT=0; tready=1 after release.
REQ-033 Reset mid-run abandons all outstanding bursts; after release no AXI activity until a new START/trigger sequence.

Verification
REQ-034 ADDR=0x1000_0010, NBURST=3, BURST_LEN=16, 64-bit, slave always ready -> awaddr 0x1000_0000/0080/0100, 48 beats, wlast on beats 15/31/47, DONE=1.
REQ-035 MAX_OUTSTANDING=4, bvalid withheld, NBURST=6 -> exactly 4 AW handshakes, then 1 new AW per B response.
REQ-036 tvalid=1, wready=0 -> tready drops after 64 words; releasing wready drains data in order, none lost.
REQ-037 bresp=10 on bursts 2 and 5 of 8 -> ERR_CNT=2 at DONE; second run's LOAD clears it to 0.
REQ-038 NBURST=0 -> no AW/W activity, DONE=1 within 4 cycles of synchronised trigger.
REQ-039 rstn pulsed low mid-burst (beat 7) -> awvalid/wvalid/bready=0 immediately, FSM IDLE, ERR_CNT=0.
